// File: rtl/multicycle_controller.sv
// Multicycle control unit for a MIPS-subset datapath.
// Instructions run through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). Unsupported
// instructions either halt in TRAP or are retired as NOPs; the choice is made
// at build time by the CTRL_ILLEGAL_TRAP_EN macro.
//
// Parameters:
//   WORD_WIDTH  instruction width (>= 32); opcode = inst[WORD_WIDTH-1 -: 6], funct = inst[5:0]
//   CNT_WIDTH   width of the retired-instruction counter
// Ports:
//   clk, nrst             clock, asynchronous active-low reset
//   inst                  instruction register contents (valid from DECODE on)
//   alu_zero, mem_ready   datapath / memory status
//   mem_read, data_wr     memory read / write requests
//   ir_write, pc_write    IR load, PC update
//   reg_write, reg_dst    register file write enable, rd (1) / rt (0) select
//   alu_src, mem_to_reg   immediate operand B, write-back from memory
//   pc_src, jump, jal, jr branch target, jump target, link to r31, PC from rs
//   sll, srl              shift operand selects
//   alusel                ALU operation code
//   instret               retired-instruction count (wraps)
//   trap                  illegal-instruction halt flag
module multicycle_controller #(
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [WORD_WIDTH-1:0] inst,
  input  logic                  alu_zero,
  input  logic                  mem_ready,
  output logic                  mem_read,
  output logic                  data_wr,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic                  reg_dst,
  output logic                  alu_src,
  output logic                  mem_to_reg,
  output logic                  pc_src,
  output logic                  jump,
  output logic                  jal,
  output logic                  jr,
  output logic                  sll,
  output logic                  srl,
  output logic [3:0]            alusel,
  output logic [CNT_WIDTH-1:0]  instret,
  output logic                  trap
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_OR  = 4'b1111;
  localparam logic [3:0] ALU_SLT = 4'b1110;
  localparam logic [3:0] ALU_SLL = 4'b1100;
  localparam logic [3:0] ALU_SRL = 4'b1000;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t               state;
  logic [5:0]           op_q;
  logic [5:0]           fn_q;
  logic [3:0]           alusel_q;
  logic                 alu_src_q;
  logic                 reg_dst_q;
  logic                 sll_q;
  logic                 srl_q;
  logic [CNT_WIDTH-1:0] instret_q;

  // Operand/immediate bits between opcode and funct are datapath-only.
  logic [5:0] dec_op;
  logic [5:0] dec_fn;
  logic       unused_inst_bits;
  assign dec_op           = inst[WORD_WIDTH-1 -: 6];
  assign dec_fn           = inst[5:0];
  assign unused_inst_bits = ^inst[WORD_WIDTH-7:6];

  // Decode of the live instruction word; captured into registers in DECODE.
  logic       dec_legal;
  logic [3:0] dec_alusel;
  logic       dec_alu_src;
  logic       dec_reg_dst;
  logic       dec_sll;
  logic       dec_srl;

  always_comb begin
    dec_legal   = 1'b1;
    dec_alusel  = '0;
    dec_alu_src = 1'b0;
    dec_reg_dst = 1'b0;
    dec_sll     = 1'b0;
    dec_srl     = 1'b0;
    case (dec_op)
      OP_RTYPE: begin
        dec_reg_dst = 1'b1;
        case (dec_fn)
          FN_ADD: dec_alusel = ALU_ADD;
          FN_SUB: dec_alusel = ALU_SUB;
          FN_AND: dec_alusel = ALU_AND;
          FN_OR:  dec_alusel = ALU_OR;
          FN_SLT: dec_alusel = ALU_SLT;
          FN_SLL: begin dec_alusel = ALU_SLL; dec_sll = 1'b1; end
          FN_SRL: begin dec_alusel = ALU_SRL; dec_srl = 1'b1; end
          FN_JR:  dec_reg_dst = 1'b0;
          default: begin dec_legal = 1'b0; dec_reg_dst = 1'b0; end
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin dec_alusel = ALU_ADD; dec_alu_src = 1'b1; end
      OP_ANDI: begin dec_alusel = ALU_AND; dec_alu_src = 1'b1; end
      OP_ORI:  begin dec_alusel = ALU_OR;  dec_alu_src = 1'b1; end
      OP_SLTI: begin dec_alusel = ALU_SLT; dec_alu_src = 1'b1; end
      OP_BEQ, OP_BNE: dec_alusel = ALU_SUB;
      OP_J, OP_JAL: ;
      default: dec_legal = 1'b0;
    endcase
  end

  // Instruction class from the latched fields (stable from EXEC to next DECODE).
  logic is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr;
  assign is_lw  = (op_q == OP_LW);
  assign is_sw  = (op_q == OP_SW);
  assign is_beq = (op_q == OP_BEQ);
  assign is_bne = (op_q == OP_BNE);
  assign is_j   = (op_q == OP_J);
  assign is_jal = (op_q == OP_JAL);
  assign is_jr  = (op_q == OP_RTYPE) && (fn_q == FN_JR);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_FETCH;
      op_q      <= '0;
      fn_q      <= '0;
      alusel_q  <= '0;
      alu_src_q <= 1'b0;
      reg_dst_q <= 1'b0;
      sll_q     <= 1'b0;
      srl_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          op_q      <= dec_op;
          fn_q      <= dec_fn;
          alusel_q  <= dec_alusel;
          alu_src_q <= dec_alu_src;
          reg_dst_q <= dec_reg_dst;
          sll_q     <= dec_sll;
          srl_q     <= dec_srl;
          if (dec_legal) begin
            state <= S_EXEC;
          end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state <= S_TRAP;
`else
            state     <= S_FETCH;
            instret_q <= instret_q + CNT_WIDTH'(1);
`endif
          end
        end
        S_EXEC: begin
          if (is_lw || is_sw) begin
            state <= S_MEM;
          end else if (is_beq || is_bne || is_j || is_jal || is_jr) begin
            state     <= S_FETCH;
            instret_q <= instret_q + CNT_WIDTH'(1);
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_lw) begin
              state <= S_WB;
            end else begin
              state     <= S_FETCH;
              instret_q <= instret_q + CNT_WIDTH'(1);
            end
          end
        end
        S_WB: begin
          state     <= S_FETCH;
          instret_q <= instret_q + CNT_WIDTH'(1);
        end
        S_TRAP: state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Strobes are decoded from state and the live handshake inputs (ir_write and
  // branch outcome must react in the same cycle). Gating with nrst keeps every
  // output at 0 while reset is held, yet FETCH drives mem_read in the very
  // first cycle after release.
  always_comb begin
    mem_read   = 1'b0;
    data_wr    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    jump       = 1'b0;
    jal        = 1'b0;
    jr         = 1'b0;
    trap       = 1'b0;
    if (nrst) begin
      case (state)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          if (is_beq) begin
            pc_src   = alu_zero;
            pc_write = alu_zero;
          end else if (is_bne) begin
            pc_src   = !alu_zero;
            pc_write = !alu_zero;
          end else if (is_j) begin
            jump     = 1'b1;
            pc_write = 1'b1;
          end else if (is_jal) begin
            jump      = 1'b1;
            pc_write  = 1'b1;
            jal       = 1'b1;
            reg_write = 1'b1;
          end else if (is_jr) begin
            jr       = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_MEM: begin
          mem_read = is_lw;
          data_wr  = is_sw;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_lw;
        end
        S_TRAP: trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign alusel  = alusel_q;
  assign alu_src = alu_src_q;
  assign reg_dst = reg_dst_q;
  assign sll     = sll_q;
  assign srl     = srl_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus process pushes the
// expected per-cycle output picture, a monitor pops and compares on negedge.
// A second instance with a 3-bit counter exercises counter wrap.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] inst = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b1;

  logic mem_read, data_wr, ir_write, pc_write, reg_write, reg_dst, alu_src;
  logic mem_to_reg, pc_src, jump, jal, jr, sll, srl, trap;
  logic [3:0]  alusel;
  logic [15:0] instret;

  logic w_mem_read, w_data_wr, w_ir_write, w_pc_write, w_reg_write, w_reg_dst, w_alu_src;
  logic w_mem_to_reg, w_pc_src, w_jump, w_jal, w_jr, w_sll, w_srl, w_trap;
  logic [3:0] w_alusel;
  logic [2:0] w_instret;

  multicycle_controller dut (
    .clk(clk), .nrst(nrst), .inst(inst), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .data_wr(data_wr), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .pc_src(pc_src), .jump(jump), .jal(jal), .jr(jr), .sll(sll), .srl(srl),
    .alusel(alusel), .instret(instret), .trap(trap)
  );

  multicycle_controller #(.WORD_WIDTH(32), .CNT_WIDTH(3)) dut_wrap (
    .clk(clk), .nrst(nrst), .inst(inst), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_read(w_mem_read), .data_wr(w_data_wr), .ir_write(w_ir_write), .pc_write(w_pc_write),
    .reg_write(w_reg_write), .reg_dst(w_reg_dst), .alu_src(w_alu_src), .mem_to_reg(w_mem_to_reg),
    .pc_src(w_pc_src), .jump(w_jump), .jal(w_jal), .jr(w_jr), .sll(w_sll), .srl(w_srl),
    .alusel(w_alusel), .instret(w_instret), .trap(w_trap)
  );

  always #5 clk = ~clk;

  // Strobe vector {mem_read,data_wr,ir_write,pc_write,reg_write,mem_to_reg,pc_src,jump,jal,jr}
  localparam logic [9:0] NONE = 10'd0;
  localparam logic [9:0] MR   = 10'b1000000000;
  localparam logic [9:0] DW   = 10'b0100000000;
  localparam logic [9:0] IRW  = 10'b0010000000;
  localparam logic [9:0] PCW  = 10'b0001000000;
  localparam logic [9:0] RW   = 10'b0000100000;
  localparam logic [9:0] M2R  = 10'b0000010000;
  localparam logic [9:0] PCS  = 10'b0000001000;
  localparam logic [9:0] JMP  = 10'b0000000100;
  localparam logic [9:0] JAL  = 10'b0000000010;
  localparam logic [9:0] JRS  = 10'b0000000001;

  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_J = 4, K_JAL = 5, K_JR = 6, K_ILL = 7;

  typedef struct packed {
    logic [9:0]  st;
    logic [7:0]  dec;   // {alusel, alu_src, reg_dst, sll, srl}
    logic [15:0] cnt;
    logic        trp;
    logic [2:0]  wcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;

  logic [7:0]  held  = '0;
  logic [15:0] cnt   = '0;
  logic        trap_x = 1'b0;

  task automatic cyc(input logic [9:0] st, input logic mr, input logic az, input logic rn);
    exp_t e;
    @(posedge clk);
    #1;
    nrst      = rn;
    mem_ready = mr;
    alu_zero  = az;
    if (!rn) begin
      cnt    = '0;
      held   = '0;
      trap_x = 1'b0;
    end
    e.st   = rn ? st : NONE;
    e.dec  = held;
    e.cnt  = cnt;
    e.trp  = trap_x;
    e.wcnt = cnt[2:0];
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'h0, fn};
  endfunction

  task automatic do_instr(input logic [31:0] word, input int kind, input logic [7:0] dec,
                          input logic az, input logic take, input int waits);
    cyc(MR | IRW | PCW, 1'b1, 1'b0, 1'b1);
    inst = word;
    cyc(NONE, 1'b1, az, 1'b1);
    if (kind == K_ILL) begin
      held = '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      trap_x = 1'b1;
      repeat (3) cyc(NONE, 1'b1, 1'b0, 1'b1);
`else
      cnt++;
`endif
      return;
    end
    held = dec;
    case (kind)
      K_BR:  begin cyc(take ? (PCS | PCW) : NONE, 1'b1, az, 1'b1); cnt++; end
      K_J:   begin cyc(JMP | PCW, 1'b1, az, 1'b1); cnt++; end
      K_JAL: begin cyc(JMP | PCW | JAL | RW, 1'b1, az, 1'b1); cnt++; end
      K_JR:  begin cyc(JRS | PCW, 1'b1, az, 1'b1); cnt++; end
      K_ALU: begin
        cyc(NONE, 1'b1, az, 1'b1);
        cyc(RW, 1'b1, az, 1'b1);
        cnt++;
      end
      K_LW: begin
        cyc(NONE, 1'b1, az, 1'b1);
        for (int i = 0; i < waits; i++) cyc(MR, 1'b0, az, 1'b1);
        cyc(MR, 1'b1, az, 1'b1);
        cyc(RW | M2R, 1'b1, az, 1'b1);
        cnt++;
      end
      K_SW: begin
        cyc(NONE, 1'b1, az, 1'b1);
        for (int i = 0; i < waits; i++) cyc(DW, 1'b0, az, 1'b1);
        cyc(DW, 1'b1, az, 1'b1);
        cnt++;
      end
      default: ;
    endcase
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc_no++;
        n_checks++;
        if ({mem_read, data_wr, ir_write, pc_write, reg_write, mem_to_reg, pc_src, jump, jal, jr} !== e.st) begin
          n_fail++;
          $display("FAIL strobes cycle %0d: got %b expected %b", cyc_no,
                   {mem_read, data_wr, ir_write, pc_write, reg_write, mem_to_reg, pc_src, jump, jal, jr}, e.st);
        end
        n_checks++;
        if ({alusel, alu_src, reg_dst, sll, srl} !== e.dec) begin
          n_fail++;
          $display("FAIL decode cycle %0d: got %b expected %b", cyc_no, {alusel, alu_src, reg_dst, sll, srl}, e.dec);
        end
        n_checks++;
        if (instret !== e.cnt) begin
          n_fail++;
          $display("FAIL instret cycle %0d: got %0d expected %0d", cyc_no, instret, e.cnt);
        end
        n_checks++;
        if (trap !== e.trp) begin
          n_fail++;
          $display("FAIL trap cycle %0d: got %b expected %b", cyc_no, trap, e.trp);
        end
        n_checks++;
        if (w_instret !== e.wcnt) begin
          n_fail++;
          $display("FAIL wrap_instret cycle %0d: got %0d expected %0d", cyc_no, w_instret, e.wcnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, queue depth %0d expected 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two cycles: all outputs 0.
    cyc(NONE, 1'b1, 1'b0, 1'b0);
    cyc(NONE, 1'b1, 1'b0, 1'b0);

    do_instr(mk(6'h00, 6'h20), K_ALU, 8'b0001_0100, 1'b0, 1'b0, 0);  // ADD
    do_instr(mk(6'h23, 6'h04), K_LW,  8'b0001_1000, 1'b0, 1'b0, 3);  // LW, 3 wait cycles
    do_instr(mk(6'h04, 6'h00), K_BR,  8'b0011_0000, 1'b1, 1'b1, 0);  // BEQ taken
    do_instr(mk(6'h05, 6'h00), K_BR,  8'b0011_0000, 1'b1, 1'b0, 0);  // BNE not taken
    do_instr(mk(6'h00, 6'h22), K_ALU, 8'b0011_0100, 1'b0, 1'b0, 0);  // SUB
    do_instr(mk(6'h0D, 6'h11), K_ALU, 8'b1111_1000, 1'b0, 1'b0, 0);  // ORI
    do_instr(mk(6'h2B, 6'h08), K_SW,  8'b0001_1000, 1'b0, 1'b0, 1);  // SW, 1 wait
    do_instr(mk(6'h03, 6'h00), K_JAL, 8'b0000_0000, 1'b0, 1'b0, 0);  // JAL, 3-bit counter wraps
    do_instr(mk(6'h00, 6'h00), K_ALU, 8'b1100_0110, 1'b0, 1'b0, 0);  // SLL
    do_instr(mk(6'h00, 6'h02), K_ALU, 8'b1000_0101, 1'b0, 1'b0, 0);  // SRL
    do_instr(mk(6'h00, 6'h08), K_JR,  8'b0000_0000, 1'b0, 1'b0, 0);  // JR
    do_instr(mk(6'h02, 6'h00), K_J,   8'b0000_0000, 1'b0, 1'b0, 0);  // J
    do_instr(mk(6'h0A, 6'h00), K_ALU, 8'b1110_1000, 1'b0, 1'b0, 0);  // SLTI
    do_instr(mk(6'h00, 6'h24), K_ALU, 8'b0111_0100, 1'b0, 1'b0, 0);  // AND
    do_instr(mk(6'h00, 6'h25), K_ALU, 8'b1111_0100, 1'b0, 1'b0, 0);  // OR
    do_instr(mk(6'h00, 6'h2A), K_ALU, 8'b1110_0100, 1'b0, 1'b0, 0);  // SLT
    do_instr(mk(6'h0C, 6'h3F), K_ALU, 8'b0111_1000, 1'b0, 1'b0, 0);  // ANDI
    do_instr(mk(6'h08, 6'h01), K_ALU, 8'b0001_1000, 1'b0, 1'b0, 0);  // ADDI
    do_instr(mk(6'h05, 6'h00), K_BR,  8'b0011_0000, 1'b0, 1'b1, 0);  // BNE taken
    do_instr(mk(6'h04, 6'h00), K_BR,  8'b0011_0000, 1'b0, 1'b0, 0);  // BEQ not taken

    // Reset pulse while LW waits in MEM abandons the access.
    cyc(MR | IRW | PCW, 1'b1, 1'b0, 1'b1);
    inst = mk(6'h23, 6'h00);
    cyc(NONE, 1'b1, 1'b0, 1'b1);
    held = 8'b0001_1000;
    cyc(NONE, 1'b1, 1'b0, 1'b1);
    cyc(MR, 1'b0, 1'b0, 1'b1);
    cyc(NONE, 1'b0, 1'b0, 1'b0);
    do_instr(mk(6'h00, 6'h20), K_ALU, 8'b0001_0100, 1'b0, 1'b0, 0);  // ADD after reset

    do_instr(mk(6'h3F, 6'h00), K_ILL, 8'b0000_0000, 1'b0, 1'b0, 0);  // illegal opcode
    cyc(NONE, 1'b1, 1'b0, 1'b0);
    do_instr(mk(6'h00, 6'h22), K_ALU, 8'b0011_0100, 1'b0, 1'b0, 0);  // SUB after reset

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: queue depth %0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
